alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width; legal values are powers of two from 4 to 32.
REQ-002 SHALL have port Clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous active-low reset.
REQ-004 SHALL have port iStart  input  1  operation request, sampled on a rising edge.
REQ-005 SHALL have port iALUControl  input  4  opcode (REQ-014).
REQ-006 SHALL have ports iA and iB  input  WIDTH each  operands.
REQ-007 SHALL have port iRegOutputALU  input  1  flag-set select: 0 selects set A, 1 selects set B.
REQ-008 SHALL have port oALUOut  output  WIDTH  registered result.
REQ-009 SHALL have ports oReady, oDone and oIllegal  output  1 each  idle indicator, completion pulse and illegal-opcode pulse.
REQ-010 SHALL have ports N_A, Z_A, C_A, V_A, N_B, Z_B, C_B, V_B  output  1 each  registered flag sets A and B.

Function
REQ-011 SHALL implement FSM states IDLE, RUN and DONE; oReady=1 only in IDLE.
REQ-012 SHALL accept a request only when iStart=1 in IDLE; iStart in RUN/DONE is ignored (no queuing).
REQ-013 SHALL capture iA, iB, iALUControl and iRegOutputALU at accept; later input changes are ignored for that operation.
REQ-014 SHALL decode opcodes: 0 ADD; 1 SUB A-B; 2 RSUB B-A; 3 AND; 4 OR; 5 XOR; 6 SHL1; 7 SHR1 logical; 8 ADC (A+B+C of the selected set); 9 SBC (A-B-C of the selected set); 10 SHLN; 11 SHRN; 12 MUL; 13-15 illegal.
REQ-015 SHALL treat opcodes 0-9 as single-cycle: IDLE->DONE at accept; oDone high in the cycle after accept (latency 1).
REQ-016 SHALL take shift count n for SHLN/SHRN from iB[log2(WIDTH)-1:0]; if n=0, go IDLE->DONE (latency 1) with result=A and C=0.
REQ-017 SHALL, for n>0, go IDLE->RUN and shift one bit per RUN cycle; after n steps go to DONE; oDone latency n+1.
REQ-018 SHALL implement MUL as unsigned shift-add, one multiplier bit per RUN cycle for WIDTH cycles; latency WIDTH+1; result = low WIDTH bits of product.
REQ-019 SHALL hold DONE for exactly one cycle, then return to IDLE; oDone=1 only in DONE.
REQ-020 SHALL, in DONE, update oALUOut and only the selected flag set; the unselected set holds its value.
REQ-021 SHALL set flags as follows: N=result[WIDTH-1]; Z=(result==0).
REQ-022 SHALL set C as follows: ADD/ADC carry-out; SUB/SBC/RSUB borrow (1 when minuend < subtrahend plus borrow-in); shifts the last bit shifted out; MUL 1 when the high product half is nonzero; logic ops 0.
REQ-023 SHALL set V to two's-complement overflow for ADD/SUB/RSUB/ADC/SBC and 0 for all other ops.
REQ-024 SHALL, for illegal opcodes, go IDLE->DONE with oDone=1 and oIllegal=1 in DONE, leaving oALUOut and all flags unchanged.
REQ-025 SHALL keep oALUOut and flags stable between DONE cycles.

Reset
REQ-026 SHALL, when Reset=0 on a rising edge, force state IDLE, oALUOut=0, all eight flags=0, oDone=0, oIllegal=0 and oReady=1 after that edge.
REQ-027 SHALL abort any RUN operation on reset with no oDone and no result/flag update; Reset has priority over iStart in the same cycle.

Verification (WIDTH=8)
REQ-028 SHALL verify: ADD 0xFF+0x01, select A -> after 1 cycle oDone=1, oALUOut=0x00, Z_A=1, C_A=1, V_A=0, N_A=0; set B unchanged.
REQ-029 SHALL verify: SUB 0x05-0x07, select B -> oALUOut=0xFE, N_B=1, C_B=1, Z_B=0; then SBC 0x10-0x01 with select B -> 0x0E.
REQ-030 SHALL verify: SHLN A=0x81, B=0x03 -> oReady low 3 cycles, oDone 4 cycles after accept, oALUOut=0x08, C=0; with B=0x00 -> 0x81, latency 1.
REQ-031 SHALL verify: MUL 0x0D*0x0B -> oDone 9 cycles after accept, oALUOut=0x8F, N=1, C=0; 0x20*0x10 -> 0x00, Z=1, C=1.
REQ-032 SHALL verify: iStart pulsed during MUL RUN is ignored; Reset=0 at the 4th RUN cycle -> no oDone, oALUOut=0x00, flags cleared, oReady=1.
REQ-033 SHALL verify: opcode 14 -> oDone=oIllegal=1 one cycle after accept, oALUOut and flags unchanged.

Source files
------------

// File: rtl/alu_multicycle_if.sv
// Request/response bundle for the multi-cycle ALU: operands, opcode and
// flag-set select flow toward the ALU; result, status and both flag sets
// flow back.
interface alu_multicycle_if #(
    parameter int WIDTH = 8
);
    logic             iStart;
    logic [3:0]       iALUControl;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             iRegOutputALU;

    logic [WIDTH-1:0] oALUOut;
    logic             oReady;
    logic             oDone;
    logic             oIllegal;
    logic             N_A, Z_A, C_A, V_A;
    logic             N_B, Z_B, C_B, V_B;

    modport master (
        output iStart, iALUControl, iA, iB, iRegOutputALU,
        input  oALUOut, oReady, oDone, oIllegal,
        input  N_A, Z_A, C_A, V_A, N_B, Z_B, C_B, V_B
    );

    modport slave (
        input  iStart, iALUControl, iA, iB, iRegOutputALU,
        output oALUOut, oReady, oDone, oIllegal,
        output N_A, Z_A, C_A, V_A, N_B, Z_B, C_B, V_B
    );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU. Arithmetic, logic and single-bit shifts finish one cycle
// after the request is accepted; multi-bit shifts walk one bit per cycle and
// the multiply is a shift-add over WIDTH cycles. Results and flags are
// written on the edge that enters DONE, so they are already valid while
// oDone is high, and they only change again on the next completion.
module alu_multicycle #(
    parameter int WIDTH = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    alu_multicycle_if.slave   bus
);
    localparam int SW  = $clog2(WIDTH);
    localparam int CW  = SW + 1;
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_RSUB = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SHL1 = 4'd6;
    localparam logic [3:0] OP_SHR1 = 4'd7;
    localparam logic [3:0] OP_ADC  = 4'd8;
    localparam logic [3:0] OP_SBC  = 4'd9;
    localparam logic [3:0] OP_SHLN = 4'd10;
    localparam logic [3:0] OP_SHRN = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q;
    logic             sel_q;
    logic             ill_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] hi_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] sc_res;
    logic [WIDTH:0]   ext;
    logic             sc_c, sc_v, cin, in_ill, in_multi;
    logic [SW-1:0]    shamt;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_acc, step_hi;
    logic             step_c;

    logic             wb_en, wb_sel, wb_c, wb_v;
    logic [WIDTH-1:0] wb_res;

    // Decode the incoming request and compute single-cycle results directly from the live inputs.
    always_comb begin
        shamt    = bus.iB[SW-1:0];
        cin      = bus.iRegOutputALU ? bus.C_B : bus.C_A;
        ext      = '0;
        sc_res   = '0;
        sc_c     = 1'b0;
        sc_v     = 1'b0;
        in_ill   = 1'b0;
        in_multi = 1'b0;
        case (bus.iALUControl)
            OP_ADD, OP_ADC: begin
                ext    = {1'b0, bus.iA} + {1'b0, bus.iB}
                       + {{WIDTH{1'b0}}, (bus.iALUControl == OP_ADC) & cin};
                sc_res = ext[MSB:0];
                sc_c   = ext[WIDTH];
                sc_v   = (bus.iA[MSB] == bus.iB[MSB]) && (sc_res[MSB] != bus.iA[MSB]);
            end
            OP_SUB, OP_SBC: begin
                ext    = {1'b0, bus.iA} - {1'b0, bus.iB}
                       - {{WIDTH{1'b0}}, (bus.iALUControl == OP_SBC) & cin};
                sc_res = ext[MSB:0];
                sc_c   = ext[WIDTH];
                sc_v   = (bus.iA[MSB] != bus.iB[MSB]) && (sc_res[MSB] != bus.iA[MSB]);
            end
            OP_RSUB: begin
                ext    = {1'b0, bus.iB} - {1'b0, bus.iA};
                sc_res = ext[MSB:0];
                sc_c   = ext[WIDTH];
                sc_v   = (bus.iB[MSB] != bus.iA[MSB]) && (sc_res[MSB] != bus.iB[MSB]);
            end
            OP_AND:  sc_res = bus.iA & bus.iB;
            OP_OR:   sc_res = bus.iA | bus.iB;
            OP_XOR:  sc_res = bus.iA ^ bus.iB;
            OP_SHL1: begin
                sc_res = {bus.iA[MSB-1:0], 1'b0};
                sc_c   = bus.iA[MSB];
            end
            OP_SHR1: begin
                sc_res = {1'b0, bus.iA[MSB:1]};
                sc_c   = bus.iA[0];
            end
            OP_SHLN, OP_SHRN: begin
                sc_res   = bus.iA;
                in_multi = (shamt != '0);
            end
            OP_MUL:  in_multi = 1'b1;
            default: in_ill   = 1'b1;
        endcase
    end

    // One iteration of the running shift or shift-add multiply, from the working registers.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (acc_q[0] ? {1'b0, a_q} : '0);
        step_acc = acc_q;
        step_hi  = hi_q;
        step_c   = 1'b0;
        case (op_q)
            OP_SHLN: begin
                step_acc = {acc_q[MSB-1:0], 1'b0};
                step_c   = acc_q[MSB];
            end
            OP_SHRN: begin
                step_acc = {1'b0, acc_q[MSB:1]};
                step_c   = acc_q[0];
            end
            OP_MUL: begin
                step_hi  = mul_sum[WIDTH:1];
                step_acc = {mul_sum[0], acc_q[MSB:1]};
                step_c   = |mul_sum[WIDTH:1];
            end
            default: step_c = 1'b0;
        endcase
    end

    // Next-state logic plus selection of what gets written back on entry to DONE.
    always_comb begin
        state_d = state_q;
        wb_en   = 1'b0;
        wb_sel  = sel_q;
        wb_res  = step_acc;
        wb_c    = step_c;
        wb_v    = 1'b0;
        case (state_q)
            IDLE: begin
                wb_sel = bus.iRegOutputALU;
                wb_res = sc_res;
                wb_c   = sc_c;
                wb_v   = sc_v;
                if (bus.iStart) begin
                    if (in_ill) begin
                        state_d = DONE;
                    end else if (in_multi) begin
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                        wb_en   = 1'b1;
                    end
                end
            end
            RUN: begin
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    wb_en   = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, operand capture, iteration registers and architectural result/flags.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            sel_q       <= 1'b0;
            ill_q       <= 1'b0;
            a_q         <= '0;
            acc_q       <= '0;
            hi_q        <= '0;
            cnt_q       <= '0;
            bus.oALUOut <= '0;
            bus.N_A     <= 1'b0;
            bus.Z_A     <= 1'b0;
            bus.C_A     <= 1'b0;
            bus.V_A     <= 1'b0;
            bus.N_B     <= 1'b0;
            bus.Z_B     <= 1'b0;
            bus.C_B     <= 1'b0;
            bus.V_B     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.iStart) begin
                op_q  <= bus.iALUControl;
                sel_q <= bus.iRegOutputALU;
                ill_q <= in_ill;
                a_q   <= bus.iA;
                hi_q  <= '0;
                if (bus.iALUControl == OP_MUL) begin
                    acc_q <= bus.iB;
                    cnt_q <= CW'(WIDTH);
                end else begin
                    acc_q <= bus.iA;
                    cnt_q <= {1'b0, shamt};
                end
            end else if (state_q == RUN) begin
                acc_q <= step_acc;
                hi_q  <= step_hi;
                cnt_q <= cnt_q - CW'(1);
            end
            if (wb_en) begin
                bus.oALUOut <= wb_res;
                if (wb_sel) begin
                    bus.N_B <= wb_res[MSB];
                    bus.Z_B <= (wb_res == '0);
                    bus.C_B <= wb_c;
                    bus.V_B <= wb_v;
                end else begin
                    bus.N_A <= wb_res[MSB];
                    bus.Z_A <= (wb_res == '0);
                    bus.C_A <= wb_c;
                    bus.V_A <= wb_v;
                end
            end
        end
    end

    assign bus.oReady   = (state_q == IDLE);
    assign bus.oDone    = (state_q == DONE);
    assign bus.oIllegal = (state_q == DONE) && ill_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at WIDTH=8 with hand-computed expectations.
module tb_alu_multicycle;
    localparam int WIDTH = 8;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_RSUB = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_ADC  = 4'd8;
    localparam logic [3:0] OP_SBC  = 4'd9;
    localparam logic [3:0] OP_SHLN = 4'd10;
    localparam logic [3:0] OP_SHRN = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;

    logic Clock = 1'b0;
    logic Reset;
    int   tests_run  = 0;
    int   fail_count = 0;

    alu_multicycle_if #(.WIDTH(WIDTH)) bus ();

    alu_multicycle #(.WIDTH(WIDTH)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    always #5 Clock = ~Clock;

    // {N_A,Z_A,C_A,V_A,N_B,Z_B,C_B,V_B}
    logic [7:0] flags;
    assign flags = {bus.N_A, bus.Z_A, bus.C_A, bus.V_A,
                    bus.N_B, bus.Z_B, bus.C_B, bus.V_B};

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request, then scramble the inputs and count cycles until oDone.
    task automatic apply_stimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input logic sel, output int lat, output int ready_low,
                                  output logic done_seen);
        @(negedge Clock);
        bus.iALUControl   = op;
        bus.iA            = a;
        bus.iB            = b;
        bus.iRegOutputALU = sel;
        bus.iStart        = 1'b1;
        @(posedge Clock);
        lat       = 0;
        ready_low = 0;
        done_seen = 1'b0;
        while (!done_seen && lat < 40) begin
            @(negedge Clock);
            if (lat == 0) begin
                bus.iStart        = 1'b0;
                bus.iA            = 8'hA5;
                bus.iB            = 8'h5A;
                bus.iALUControl   = OP_ADD;
                bus.iRegOutputALU = ~sel;
            end
            lat++;
            if (bus.oDone) done_seen = 1'b1;
            else if (!bus.oReady) ready_low++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic sel, input int exp_lat,
                          input logic [7:0] exp_out, input logic [7:0] exp_flags,
                          input logic exp_ill);
        int   lat, ready_low;
        logic done_seen;
        apply_stimulus(op, a, b, sel, lat, ready_low, done_seen);
        check_output({tag, "_done"},  32'(done_seen), 32'd1);
        check_output({tag, "_lat"},   32'(lat), 32'(exp_lat));
        check_output({tag, "_ready"}, 32'(ready_low), 32'(exp_lat - 1));
        check_output({tag, "_out"},   32'(bus.oALUOut), 32'(exp_out));
        check_output({tag, "_flags"}, 32'(flags), 32'(exp_flags));
        check_output({tag, "_ill"},   32'(bus.oIllegal), 32'(exp_ill));
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Main directed sequence.
    initial begin
        int done_cnt;
        Reset             = 1'b0;
        bus.iStart        = 1'b0;
        bus.iALUControl   = '0;
        bus.iA            = '0;
        bus.iB            = '0;
        bus.iRegOutputALU = 1'b0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check_output("rst_out",   32'(bus.oALUOut), 32'h0);
        check_output("rst_flags", 32'(flags), 32'h0);
        check_output("rst_ready", 32'(bus.oReady), 32'd1);
        check_output("rst_done",  32'(bus.oDone), 32'd0);
        check_output("rst_ill",   32'(bus.oIllegal), 32'd0);
        Reset = 1'b1;

        run_op("add_ff_01",  OP_ADD,  8'hFF, 8'h01, 1'b0, 1, 8'h00, 8'b0110_0000, 1'b0);
        run_op("sub_05_07",  OP_SUB,  8'h05, 8'h07, 1'b1, 1, 8'hFE, 8'b0110_1010, 1'b0);
        run_op("sbc_10_01",  OP_SBC,  8'h10, 8'h01, 1'b1, 1, 8'h0E, 8'b0110_0000, 1'b0);
        run_op("shln_81_3",  OP_SHLN, 8'h81, 8'h03, 1'b0, 4, 8'h08, 8'b0000_0000, 1'b0);
        run_op("shln_81_0",  OP_SHLN, 8'h81, 8'h00, 1'b0, 1, 8'h81, 8'b1000_0000, 1'b0);
        run_op("mul_0d_0b",  OP_MUL,  8'h0D, 8'h0B, 1'b1, 9, 8'h8F, 8'b1000_1000, 1'b0);
        run_op("mul_20_10",  OP_MUL,  8'h20, 8'h10, 1'b0, 9, 8'h00, 8'b0110_1000, 1'b0);
        run_op("rsub_03_01", OP_RSUB, 8'h03, 8'h01, 1'b1, 1, 8'hFE, 8'b0110_1010, 1'b0);
        run_op("shrn_81_1",  OP_SHRN, 8'h81, 8'h01, 1'b0, 2, 8'h40, 8'b0010_1010, 1'b0);
        run_op("and_0f_f0",  OP_AND,  8'h0F, 8'hF0, 1'b1, 1, 8'h00, 8'b0010_0100, 1'b0);
        run_op("adc_7f_00",  OP_ADC,  8'h7F, 8'h00, 1'b0, 1, 8'h80, 8'b1001_0100, 1'b0);
        run_op("illegal_14", 4'd14,   8'h12, 8'h34, 1'b0, 1, 8'h80, 8'b1001_0100, 1'b1);

        // MUL aborted by reset in its 4th RUN cycle, with a stray start pulse mid-run.
        @(negedge Clock);
        bus.iALUControl   = OP_MUL;
        bus.iA            = 8'h0D;
        bus.iB            = 8'h0B;
        bus.iRegOutputALU = 1'b0;
        bus.iStart        = 1'b1;
        @(posedge Clock);
        done_cnt = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge Clock);
            bus.iStart = (i == 2);
            if (i == 2) bus.iALUControl = OP_ADD;
            if (bus.oDone) done_cnt++;
            if (i == 3) check_output("abort_busy", 32'(bus.oReady), 32'd0);
            if (i == 4) Reset = 1'b0;
        end
        @(negedge Clock);
        check_output("abort_nodone", 32'(done_cnt + int'(bus.oDone)), 32'd0);
        check_output("abort_out",    32'(bus.oALUOut), 32'h0);
        check_output("abort_flags",  32'(flags), 32'h0);
        check_output("abort_ready",  32'(bus.oReady), 32'd1);
        Reset = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clock);
            if (bus.oDone) done_cnt++;
        end
        check_output("no_queued_op", 32'(done_cnt), 32'd0);

        run_op("add_01_01",  OP_ADD,  8'h01, 8'h01, 1'b0, 1, 8'h02, 8'b0000_0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end
endmodule
